// File: rtl/types_pkg.sv
// Shared ALU types: operation select, operand/result widths and the
// command record carried through the sequencer's FIFO.
package types_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_type;

   localparam int OPERAND_W = 16;
   localparam int RESULT_W  = 32;

   typedef struct packed {
      logic [OPERAND_W-1:0] value1;
      logic [OPERAND_W-1:0] value2;
      op_type               mode;
   } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Small command FIFO for the ALU sequencer. Head entry is readable
// combinationally so the sequencer can issue it on the popping edge.
// Pointers wrap modulo DEPTH; count is one bit wider so full != empty.
module alu_cmd_fifo
   import types_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  alu_cmd_t               wr_data,
   output alu_cmd_t               rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   alu_cmd_t      mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   // Next pointer/occupancy; requests against full/empty are ignored.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers, cleared by reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset since the pointers gate reads.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands, issues them one at a time to the ALU, waits the
// ALU latency, captures result/correct and returns them in order.
module alu_op_sequencer
   import types_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int ALU_LATENCY = 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [OPERAND_W-1:0]   cmd_value1,
   input  logic [OPERAND_W-1:0]   cmd_value2,
   input  op_type                 cmd_mode,
   output logic [OPERAND_W-1:0]   value1,
   output logic [OPERAND_W-1:0]   value2,
   output op_type                 mode,
   input  logic [RESULT_W-1:0]    result,
   input  logic [OPERAND_W-1:0]   correct,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [RESULT_W-1:0]    rsp_result,
   output logic [OPERAND_W-1:0]   rsp_correct,
   output logic [$clog2(DEPTH):0] count
);

   localparam int WAIT_W = $clog2(ALU_LATENCY + 1);
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ALU_LATENCY);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
   alu_cmd_t             issue_q, issue_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [RESULT_W-1:0]  rsp_result_q, rsp_result_d;
   logic [OPERAND_W-1:0] rsp_correct_q, rsp_correct_d;

   alu_cmd_t cmd_in, fifo_head;
   logic     fifo_pop, fifo_full, fifo_empty;

   assign cmd_in = '{value1: cmd_value1, value2: cmd_value2, mode: cmd_mode};

   alu_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (cmd_valid),
      .pop     (fifo_pop),
      .wr_data (cmd_in),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (count)
   );

   assign cmd_ready   = !fifo_full;
   assign value1      = issue_q.value1;
   assign value2      = issue_q.value2;
   assign mode        = issue_q.mode;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_correct = rsp_correct_q;

   // Sequencer next state: issue from FIFO head, count down, capture, hand off.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      issue_d       = issue_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_result_d  = rsp_result_q;
      rsp_correct_d = rsp_correct_q;
      fifo_pop      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               issue_d    = fifo_head;
               wait_cnt_d = WAIT_LOAD;
               state_d    = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (wait_cnt_q == WAIT_LAST) begin
               rsp_result_d  = result;
               rsp_correct_d = correct;
               rsp_valid_d   = 1'b1;
               state_d       = ST_RESP;
            end else begin
               wait_cnt_d = wait_cnt_q - 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               if (!fifo_empty) begin
                  // Back-to-back: next command issues on the handshake edge.
                  fifo_pop   = 1'b1;
                  issue_d    = fifo_head;
                  wait_cnt_d = WAIT_LOAD;
                  state_d    = ST_EXEC;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer registers; reset drops any in-flight op and pending response.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         wait_cnt_q    <= '0;
         issue_q       <= '{value1: '0, value2: '0, mode: op_type'(0)};
         rsp_valid_q   <= 1'b0;
         rsp_result_q  <= '0;
         rsp_correct_q <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         issue_q       <= issue_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_result_q  <= rsp_result_d;
         rsp_correct_q <= rsp_correct_d;
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a combinational ALU stand-in:
// result = {value2, value1}, correct = (value1 + value2) ^ mode, both
// optionally XORed with a noise word to emulate a changing ALU output.
module tb_alu_op_sequencer;
   import types_pkg::*;

   logic                   clock;
   logic                   reset;
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [OPERAND_W-1:0]   cmd_value1, cmd_value2;
   op_type                 cmd_mode;
   logic [OPERAND_W-1:0]   value1, value2;
   op_type                 mode;
   logic [RESULT_W-1:0]    result;
   logic [OPERAND_W-1:0]   correct;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [RESULT_W-1:0]    rsp_result;
   logic [OPERAND_W-1:0]   rsp_correct;
   logic [2:0]             count;
   logic [31:0]            noise;

   int checks = 0;
   int passed = 0;

   logic [31:0] exp_res_q [$];
   logic [15:0] exp_cor_q [$];
   alu_cmd_t    send_q    [$];

   alu_op_sequencer #(.DEPTH(4), .ALU_LATENCY(1)) dut (
      .clock       (clock),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_value1  (cmd_value1),
      .cmd_value2  (cmd_value2),
      .cmd_mode    (cmd_mode),
      .value1      (value1),
      .value2      (value2),
      .mode        (mode),
      .result      (result),
      .correct     (correct),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_correct (rsp_correct),
      .count       (count)
   );

   assign result  = {value2, value1} ^ noise;
   assign correct = (value1 + value2) ^ 16'(mode) ^ noise[15:0];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] exp_res(input logic [15:0] a, input logic [15:0] b);
      return {b, a};
   endfunction

   function automatic logic [15:0] exp_cor(input logic [15:0] a, input logic [15:0] b, input op_type m);
      logic [15:0] s;
      s = a + b;
      return s ^ 16'(m);
   endfunction

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Feeds send_q (and any command already on the port) while collecting
   // responses in order against the expected queues.
   task automatic drain(input int n_rsp, input bit rand_ready);
      int  got;
      bit  acc, hs;
      got = 0;
      for (int cyc = 0; cyc < 400 && got < n_rsp; cyc++) begin
         if (!cmd_valid && send_q.size() != 0) begin
            cmd_value1 = send_q[0].value1;
            cmd_value2 = send_q[0].value2;
            cmd_mode   = send_q[0].mode;
            cmd_valid  = 1'b1;
            void'(send_q.pop_front());
         end
         rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         acc = cmd_valid && cmd_ready;
         hs  = rsp_valid && rsp_ready;
         if (acc) begin
            exp_res_q.push_back(exp_res(cmd_value1, cmd_value2));
            exp_cor_q.push_back(exp_cor(cmd_value1, cmd_value2, cmd_mode));
         end
         if (hs) begin
            if (exp_res_q.size() == 0) begin
               chk("unexpected_rsp", rsp_result, 32'hDEAD_BEEF);
            end else begin
               chk($sformatf("rsp_result[%0d]", got), rsp_result, exp_res_q.pop_front());
               chk($sformatf("rsp_correct[%0d]", got), 32'(rsp_correct), 32'(exp_cor_q.pop_front()));
            end
            got++;
         end
         tick();
         if (acc) cmd_valid = 1'b0;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      chk("drain_rsp_count", got, n_rsp);
   endtask

   initial begin
      bit seen;
      alu_cmd_t c;
      reset      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_value1 = '0;
      cmd_value2 = '0;
      cmd_mode   = op_type'(0);
      rsp_ready  = 1'b0;
      noise      = '0;

      // 1. Reset state
      tick();
      tick();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_value1", value1, 0);
      chk("rst_mode", mode, 0);
      chk("rst_rsp_result", rsp_result, 0);
      reset = 1'b1;
      tick();
      chk("post_rst_cmd_ready", cmd_ready, 1);

      // 2. Single command latency
      cmd_value1 = 16'd3;
      cmd_value2 = 16'd5;
      cmd_mode   = op_type'(0);
      cmd_valid  = 1'b1;
      rsp_ready  = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("t2_count_after_accept", count, 1);
      chk("t2_value1_no_bypass", value1, 0);
      tick();
      chk("t2_value1", value1, 3);
      chk("t2_value2", value2, 5);
      chk("t2_rsp_valid_early", rsp_valid, 0);
      chk("t2_count_after_pop", count, 0);
      tick();
      chk("t2_rsp_valid", rsp_valid, 1);
      chk("t2_rsp_result", rsp_result, 32'h0005_0003);
      chk("t2_rsp_correct", rsp_correct, 16'd8);
      tick();
      chk("t2_rsp_released", rsp_valid, 0);
      tick();

      // 3. Fill with rsp_ready low: five accepted, sixth held at the port
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cmd_value1 = 16'h0010 + 16'(i);
         cmd_value2 = 16'h0100 + 16'(i);
         cmd_mode   = op_type'(2'(i));
         cmd_valid  = 1'b1;
         chk($sformatf("t3_ready[%0d]", i), cmd_ready, 1);
         exp_res_q.push_back(exp_res(cmd_value1, cmd_value2));
         exp_cor_q.push_back(exp_cor(cmd_value1, cmd_value2, cmd_mode));
         tick();
      end
      cmd_value1 = 16'h0015;
      cmd_value2 = 16'h0105;
      cmd_mode   = op_type'(1);
      chk("t3_count_full", count, 4);
      chk("t3_cmd_ready_full", cmd_ready, 0);
      chk("t3_rsp_valid", rsp_valid, 1);
      chk("t3_rsp_result", rsp_result, 32'h0100_0010);
      tick();
      tick();
      chk("t3_count_held", count, 4);
      chk("t3_cmd_ready_held", cmd_ready, 0);

      // 4. Response and operands stable while ALU output toggles
      for (int i = 0; i < 10; i++) begin
         noise = $urandom;
         tick();
         chk($sformatf("t4_rsp_result[%0d]", i), rsp_result, 32'h0100_0010);
         chk($sformatf("t4_rsp_correct[%0d]", i), rsp_correct, 16'h0110);
         chk($sformatf("t4_value1[%0d]", i), value1, 16'h0010);
      end
      noise = '0;
      chk("t4_count", count, 4);
      drain(6, 1'b0);
      tick();

      // 5. Eight commands, random rsp_ready, strict ordering
      for (int i = 0; i < 8; i++) begin
         c.value1 = 16'(i);
         c.value2 = 16'(i * 3 + 2);
         c.mode   = op_type'(2'(i));
         send_q.push_back(c);
      end
      drain(8, 1'b1);
      seen = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rsp_valid) seen = 1'b1;
      end
      chk("t5_no_extra_rsp", seen, 0);
      chk("t5_count_empty", count, 0);

      // 6. Reset during EXEC with three commands queued
      for (int i = 0; i < 5; i++) begin
         cmd_value1 = 16'h0020 + 16'(i);
         cmd_value2 = 16'h0200 + 16'(i);
         cmd_mode   = op_type'(2'(i));
         cmd_valid  = 1'b1;
         rsp_ready  = (i == 4);
         if (i == 4) begin
            chk("t6_first_rsp_valid", rsp_valid, 1);
            chk("t6_first_rsp_result", rsp_result, 32'h0200_0020);
         end
         tick();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      chk("t6_count_before_rst", count, 3);
      chk("t6_exec_rsp_valid", rsp_valid, 0);
      chk("t6_exec_value1", value1, 16'h0021);
      reset     = 1'b0;
      rsp_ready = 1'b1;
      tick();
      reset = 1'b1;
      chk("t6_count_after_rst", count, 0);
      chk("t6_rsp_valid_after_rst", rsp_valid, 0);
      chk("t6_cmd_ready_after_rst", cmd_ready, 1);
      chk("t6_value1_after_rst", value1, 0);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (rsp_valid) seen = 1'b1;
      end
      chk("t6_no_stale_rsp", seen, 0);
      chk("t6_count_stays_empty", count, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
